ax25_hdlc_framer: RTL and testbench

- Packetizing stage directly upstream of the NCO. Runs in the CLK_ADC domain.
- Accepts payload bytes from the serial receive path over a valid/ready handshake and emits an HDLC frame as a single bit stream: flag preamble, bit-stuffed payload, optional FCS, flag tail, NRZI-encoded.
- Drives the NCO DATA and DET inputs directly. DET keys the carrier for the whole frame.

---
 rtl/ax25_hdlc_framer.sv | 219 +++++++++++++++++++++
 tb/tb_ax25_hdlc_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ax25_hdlc_framer.sv
// AX.25 HDLC framer: flag preamble, bit-stuffed payload, optional FCS, flag tail, NRZI line coding.
// Optional CRC-16/X.25 frame check sequence enabled by defining HDLC_FCS_EN.
//
// state      | meaning
// S_IDLE     | carrier off, line level held, waiting for a byte and a bit strobe
// S_PREAMBLE | sending opening 0x7E flags, unstuffed
// S_PAYLOAD  | sending bit-stuffed payload bytes back to back
// S_FCS      | sending the 16-bit inverted CRC, stuffed (HDLC_FCS_EN only)
// S_TAIL     | sending closing 0x7E flags, then one quiet period before idle
module ax25_hdlc_framer #(
  parameter int PREAMBLE_FLAGS = 8,
  parameter int TAIL_FLAGS     = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [7:0] DATA_in,
  input  logic       VALID_in,
  output logic       READY_out,
  output logic       DATA,
  output logic       DET,
  output logic       BUSY
);

  localparam int          FMAX = (PREAMBLE_FLAGS > TAIL_FLAGS) ? PREAMBLE_FLAGS : TAIL_FLAGS;
  localparam int          FW   = $clog2(FMAX) + 1;
  localparam logic [15:0] FLAG = 16'h007E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_PAYLOAD,
`ifdef HDLC_FCS_EN
    S_FCS,
`endif
    S_TAIL
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_shift, w_shift_nxt;
  logic [4:0]    r_bits_left, w_bits_nxt;
  logic [FW-1:0] r_flag_cnt, w_flag_nxt;
  logic [2:0]    r_ones, w_ones_nxt;
  logic          r_level, w_level_nxt;
  logic          r_det, w_det_nxt;
  logic [7:0]    r_hold, w_hold_nxt;
  logic          r_full, w_full_nxt;

  logic          w_stuff;
  logic          w_bound;
  logic          w_tx_bit;

`ifdef HDLC_FCS_EN
  logic [15:0]   r_crc, w_crc_nxt;
  logic [15:0]   w_crc_upd;
  logic [15:0]   w_crc_cur;

  assign w_crc_upd = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ r_shift[0]) ? 16'h8408 : 16'h0000);
  assign w_crc_cur = w_stuff ? r_crc : w_crc_upd;
`endif

  // A byte (or FCS) boundary is reached once the last source bit and any stuff bit it triggers are out.
  assign w_stuff  = (r_ones == 3'd5);
  assign w_bound  = w_stuff ? (r_bits_left == 5'd0)
                            : ((r_bits_left == 5'd1) && !(r_shift[0] && (r_ones == 3'd4)));
  assign w_tx_bit = w_stuff ? 1'b0 : r_shift[0];

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bits_nxt  = r_bits_left;
    w_flag_nxt  = r_flag_cnt;
    w_ones_nxt  = r_ones;
    w_level_nxt = r_level;
    w_det_nxt   = r_det;
    w_hold_nxt  = r_hold;
    w_full_nxt  = r_full;
`ifdef HDLC_FCS_EN
    w_crc_nxt   = r_crc;
`endif

    if (VALID_in && !r_full) begin
      w_hold_nxt = DATA_in;
      w_full_nxt = 1'b1;
    end

    if (EN) begin
      case (r_state)
        S_IDLE: begin
          w_det_nxt = 1'b0;
          if (r_full) begin
            // First flag bit (a 0) goes out on this strobe.
            w_state_nxt = S_PREAMBLE;
            w_det_nxt   = 1'b1;
            w_level_nxt = ~r_level;
            w_shift_nxt = FLAG >> 1;
            w_bits_nxt  = 5'd7;
            w_flag_nxt  = FW'(PREAMBLE_FLAGS - 1);
            w_ones_nxt  = 3'd0;
`ifdef HDLC_FCS_EN
            w_crc_nxt   = 16'hFFFF;
`endif
          end
        end

        S_PREAMBLE: begin
          w_level_nxt = r_shift[0] ? r_level : ~r_level;
          w_shift_nxt = {1'b0, r_shift[15:1]};
          w_bits_nxt  = r_bits_left - 5'd1;
          if (r_bits_left == 5'd1) begin
            if (r_flag_cnt == '0) begin
              w_state_nxt = S_PAYLOAD;
              w_shift_nxt = {8'h00, r_hold};
              w_bits_nxt  = 5'd8;
              w_full_nxt  = 1'b0;
              w_ones_nxt  = 3'd0;
            end else begin
              w_shift_nxt = FLAG;
              w_bits_nxt  = 5'd8;
              w_flag_nxt  = r_flag_cnt - FW'(1);
            end
          end
        end

        S_TAIL: begin
          if (r_bits_left == 5'd0) begin
            w_state_nxt = S_IDLE;
            w_det_nxt   = 1'b0;
          end else begin
            w_level_nxt = r_shift[0] ? r_level : ~r_level;
            w_shift_nxt = {1'b0, r_shift[15:1]};
            w_bits_nxt  = r_bits_left - 5'd1;
            if ((r_bits_left == 5'd1) && (r_flag_cnt != '0)) begin
              w_shift_nxt = FLAG;
              w_bits_nxt  = 5'd8;
              w_flag_nxt  = r_flag_cnt - FW'(1);
            end
          end
        end

`ifdef HDLC_FCS_EN
        S_FCS,
`endif
        S_PAYLOAD: begin
          w_level_nxt = w_tx_bit ? r_level : ~r_level;
          if (w_stuff) begin
            w_ones_nxt = 3'd0;
          end else begin
            w_shift_nxt = {1'b0, r_shift[15:1]};
            w_bits_nxt  = r_bits_left - 5'd1;
            w_ones_nxt  = r_shift[0] ? (r_ones + 3'd1) : 3'd0;
`ifdef HDLC_FCS_EN
            if (r_state == S_PAYLOAD) w_crc_nxt = w_crc_upd;
`endif
          end
          if (w_bound) begin
            if ((r_state == S_PAYLOAD) && r_full) begin
              w_shift_nxt = {8'h00, r_hold};
              w_bits_nxt  = 5'd8;
              w_full_nxt  = 1'b0;
            end
`ifdef HDLC_FCS_EN
            else if (r_state == S_PAYLOAD) begin
              w_state_nxt = S_FCS;
              w_shift_nxt = ~w_crc_cur;
              w_bits_nxt  = 5'd16;
            end
`endif
            else begin
              w_state_nxt = S_TAIL;
              w_shift_nxt = FLAG;
              w_bits_nxt  = 5'd8;
              w_flag_nxt  = FW'(TAIL_FLAGS - 1);
              w_ones_nxt  = 3'd0;
            end
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_flag_cnt  <= '0;
      r_ones      <= '0;
      r_level     <= 1'b0;
      r_det       <= 1'b0;
      r_hold      <= '0;
      r_full      <= 1'b0;
`ifdef HDLC_FCS_EN
      r_crc       <= 16'hFFFF;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bits_left <= w_bits_nxt;
      r_flag_cnt  <= w_flag_nxt;
      r_ones      <= w_ones_nxt;
      r_level     <= w_level_nxt;
      r_det       <= w_det_nxt;
      r_hold      <= w_hold_nxt;
      r_full      <= w_full_nxt;
`ifdef HDLC_FCS_EN
      r_crc       <= w_crc_nxt;
`endif
    end
  end

  assign READY_out = !r_full;
  assign DATA      = r_level;
  assign DET       = r_det;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ax25_hdlc_framer.sv
// Scoreboard bench for ax25_hdlc_framer: stimulus queues expected NRZI-decoded bits and DET lengths,
// a monitor decodes the line on every bit strobe and compares.
module tb_ax25_hdlc_framer;

  localparam int PRE  = 1;
  localparam int TAIL = 1;

  typedef logic [7:0] bq_t [$];

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] DATA_in = 8'h00;
  logic       VALID_in = 1'b0;
  logic       READY_out;
  logic       DATA;
  logic       DET;
  logic       BUSY;

  int   checks = 0;
  int   errors = 0;
  logic exp_q [$];
  int   len_q [$];
  bit   ignore_frame = 1'b0;

  ax25_hdlc_framer #(.PREAMBLE_FLAGS(PRE), .TAIL_FLAGS(TAIL)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .DATA_in(DATA_in), .VALID_in(VALID_in),
    .READY_out(READY_out), .DATA(DATA), .DET(DET), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    forever begin
      repeat (3) @(negedge CLK);
      EN = 1'b1;
      @(negedge CLK);
      EN = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- expected-stream model ----------------
  task automatic push_flags(input int k, inout int n);
    logic [7:0] fl;
    fl = 8'h7E;
    for (int f = 0; f < k; f++)
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(fl[i]);
        n++;
      end
  endtask

  task automatic push_stuffed(input logic b, inout int ones, inout int n);
    exp_q.push_back(b);
    n++;
    if (b) begin
      ones++;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        n++;
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic push_frame(input bq_t d);
    int n;
    int ones;
    n = 0;
    ones = 0;
    push_flags(PRE, n);
    foreach (d[j])
      for (int i = 0; i < 8; i++) push_stuffed(d[j][i], ones, n);
    push_flags(TAIL, n);
    len_q.push_back(n);
  endtask

`ifdef HDLC_FCS_EN
  function automatic logic [15:0] crc_x25(input bq_t d);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[j])
      for (int i = 0; i < 8; i++)
        c = {1'b0, c[15:1]} ^ ((c[0] ^ d[j][i]) ? 16'h8408 : 16'h0000);
    return ~c;
  endfunction
`else
  task automatic push_hand(input logic [31:0] v, input int nb);
    for (int i = 0; i < nb; i++) exp_q.push_back(v[nb-1-i]);
    len_q.push_back(nb);
  endtask
`endif

  task automatic expect_frame(input bq_t d);
`ifdef HDLC_FCS_EN
    logic [15:0] f;
    f = crc_x25(d);
    d.push_back(f[7:0]);
    d.push_back(f[15:8]);
`endif
    push_frame(d);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_en(input int n);
    repeat (n) begin
      @(posedge CLK);
      while (!EN) @(posedge CLK);
    end
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    @(negedge CLK);
    while (!READY_out && g < 2000) begin
      @(negedge CLK);
      g++;
    end
    if (!READY_out) fail("send_byte_ready_timeout");
    DATA_in  = b;
    VALID_in = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    VALID_in = 1'b0;
  endtask

  task automatic send_burst(input bq_t d);
    int  i;
    int  g;
    logic rdy;
    i = 0;
    g = 0;
    while (i < d.size() && g < 5000) begin
      @(negedge CLK);
      g++;
      VALID_in = 1'b1;
      rdy = READY_out;
      DATA_in = rdy ? d[i] : 8'($urandom);
      @(posedge CLK);
      if (rdy) i++;
    end
    @(negedge CLK);
    VALID_in = 1'b0;
    if (i < d.size()) fail("send_burst_timeout");
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while ((BUSY || exp_q.size() != 0 || len_q.size() != 0) && c < 4000) begin
      @(negedge CLK);
      c++;
    end
    if (c >= 4000) fail("frame_done_timeout");
    wait_en(1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic prev_line;
    logic prev_det;
    logic en_s, rst_s, d_s, det_s;
    logic e;
    int   cnt;
    int   bitno;
    prev_line = 1'b0;
    prev_det  = 1'b0;
    cnt = 0;
    bitno = 0;
    forever begin
      @(posedge CLK);
      en_s  = EN;
      rst_s = RST_N;
      #1;
      d_s   = DATA;
      det_s = DET;
      if (!rst_s) begin
        prev_line = 1'b0;
        prev_det  = 1'b0;
        cnt = 0;
      end else if (en_s) begin
        if (det_s) begin
          if (!ignore_frame) begin
            if (exp_q.size() == 0) begin
              fail($sformatf("unexpected_bit%0d", bitno));
            end else begin
              e = exp_q.pop_front();
              check($sformatf("frame_bit%0d", bitno), int'(d_s == prev_line), int'(e));
            end
            bitno++;
          end
          cnt++;
        end else if (prev_det) begin
          if (!ignore_frame) begin
            if (len_q.size() == 0) fail("unexpected_frame_end");
            else check("det_len", cnt, len_q.pop_front());
          end
          cnt = 0;
        end
        prev_line = d_s;
        prev_det  = det_s;
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    bq_t q;
`ifndef HDLC_FCS_EN
    logic [31:0] v55;
    logic [31:0] vff;
    v55 = 32'(24'b01111110_10101010_01111110);
    vff = 32'(25'b01111110_111110111_01111110);
`endif

    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_det", int'(DET), 0);
    check("reset_data", int'(DATA), 0);
    check("reset_ready", int'(READY_out), 1);
    check("reset_busy", int'(BUSY), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    wait_en(2);

    // single byte 0x55 with handshake timing
    q.delete();
    q.push_back(8'h55);
`ifdef HDLC_FCS_EN
    expect_frame(q);
`else
    push_hand(v55, 24);
`endif
    send_byte(8'h55);
    check("ready_after_capture", int'(READY_out), 0);
    wait_en(7);
    check("ready_in_preamble", int'(READY_out), 0);
    check("busy_in_preamble", int'(BUSY), 1);
    wait_en(1);
    check("ready_after_load", int'(READY_out), 1);
    wait_done();

    // 0xFF exercises a stuff bit
    q.delete();
    q.push_back(8'hFF);
`ifdef HDLC_FCS_EN
    expect_frame(q);
`else
    push_hand(vff, 25);
`endif
    send_byte(8'hFF);
    wait_done();

    // 3-byte burst, VALID held with junk data while not ready
    q.delete();
    q.push_back(8'hA5);
    q.push_back(8'h3C);
    q.push_back(8'hF8);
    expect_frame(q);
    send_burst(q);
    wait_done();

    // "123456789" streamed gaplessly
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
`ifdef HDLC_FCS_EN
    begin
      bq_t qf;
      qf = q;
      qf.push_back(8'h6E);
      qf.push_back(8'h90);
      push_frame(qf);
    end
`else
    expect_frame(q);
`endif
    send_burst(q);
    wait_done();

    // reset in the middle of the payload
    ignore_frame = 1'b1;
    send_byte(8'h00);
    wait_en(11);
    check("busy_before_abort", int'(BUSY), 1);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    check("abort_det", int'(DET), 0);
    check("abort_data", int'(DATA), 0);
    check("abort_ready", int'(READY_out), 1);
    check("abort_busy", int'(BUSY), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    ignore_frame = 1'b0;
    q.delete();
    q.push_back(8'h81);
    expect_frame(q);
    send_byte(8'h81);
    wait_done();

    // byte arriving during the tail belongs to a second frame
    q.delete();
    q.push_back(8'h0F);
    expect_frame(q);
    send_byte(8'h0F);
    wait_en(19);
    check("busy_in_tail", int'(BUSY), 1);
    q.delete();
    q.push_back(8'hF0);
    expect_frame(q);
    send_byte(8'hF0);
    wait_done();

    check("exp_bits_left", exp_q.size(), 0);
    check("exp_frames_left", len_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
